// File: rtl/rtc_bus_cycle.sv
// Bus-cycle engine for the RTC multiplexed address/data bus: address phase, gap, data phase.
// Optional write-verify readback is enabled by defining RTC_WRITE_VERIFY_EN.
module rtc_bus_cycle #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 10,
    parameter int HOLD_CYC   = 2,
    parameter int GAP_CYC    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       verify_err,
    output logic       ad,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in
);

    localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_SS > MAX_HG) ? MAX_SS : MAX_HG;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || GAP_CYC < 1) begin : g_bad_param
        $error("rtc_bus_cycle: all timing parameters must be at least 1");
    end

    typedef enum logic [3:0] {
        IDLE, A_SET, A_STB, A_HLD, GAP, D_SET, D_STB, D_HLD, DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          wr_q;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [7:0]    rdata_q;
    logic          last_cyc;
    logic          accept;
    logic          op_rd;
    logic          gap_to_addr;
    logic          rb_next;

    // Down-counter reload value for the first cycle of each timed state.
    function automatic logic [CW-1:0] load_val(input state_t s);
        case (s)
            A_SET, D_SET: load_val = CW'(SETUP_CYC - 1);
            A_STB, D_STB: load_val = CW'(STROBE_CYC - 1);
            A_HLD, D_HLD: load_val = CW'(HOLD_CYC - 1);
            GAP:          load_val = CW'(GAP_CYC - 1);
            default:      load_val = '0;
        endcase
    endfunction

    assign last_cyc = (cnt == '0);
    assign accept   = (state == IDLE) && req;

`ifdef RTC_WRITE_VERIFY_EN
    // rb_q marks the readback pass; rb_gap_q marks a gap that leads into a fresh address phase.
    logic rb_q;
    logic rb_gap_q;
    logic verify_err_q;

    assign op_rd       = ~wr_q | rb_q;
    assign gap_to_addr = rb_gap_q;
    assign rb_next     = wr_q & ~rb_q;
    assign verify_err  = verify_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rb_q         <= 1'b0;
            rb_gap_q     <= 1'b0;
            verify_err_q <= 1'b0;
        end else begin
            if (accept) begin
                rb_q         <= 1'b0;
                rb_gap_q     <= 1'b0;
                verify_err_q <= 1'b0;
            end else if (state == D_HLD && last_cyc) begin
                if (rb_q) begin
                    verify_err_q <= (rdata_q != wdata_q);
                end else if (wr_q) begin
                    rb_q     <= 1'b1;
                    rb_gap_q <= 1'b1;
                end
            end else if (state == GAP && last_cyc) begin
                rb_gap_q <= 1'b0;
            end
        end
    end
`else
    assign op_rd       = ~wr_q;
    assign gap_to_addr = 1'b0;
    assign rb_next     = 1'b0;
    assign verify_err  = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (req)      state_n = A_SET;
            A_SET: if (last_cyc) state_n = A_STB;
            A_STB: if (last_cyc) state_n = A_HLD;
            A_HLD: if (last_cyc) state_n = GAP;
            GAP:   if (last_cyc) state_n = gap_to_addr ? A_SET : D_SET;
            D_SET: if (last_cyc) state_n = D_STB;
            D_STB: if (last_cyc) state_n = D_HLD;
            D_HLD: if (last_cyc) state_n = rb_next ? GAP : DONE;
            DONE:                state_n = IDLE;
            default:             state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                cnt <= load_val(state_n);
            end else if (!last_cyc) begin
                cnt <= cnt - 1'b1;
            end
            if (accept) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == D_STB && last_cyc && op_rd) begin
                rdata_q <= bus_in;
            end
        end
    end

    // Strobes and bus drive decode directly from the registered state.
    always_comb begin
        ad      = 1'b1;
        cs_n    = 1'b1;
        wr_n    = 1'b1;
        rd_n    = 1'b1;
        bus_oe  = 1'b0;
        bus_out = 8'h00;
        case (state)
            A_SET, A_HLD: begin
                ad      = 1'b0;
                bus_oe  = 1'b1;
                bus_out = addr_q;
            end
            A_STB: begin
                ad      = 1'b0;
                bus_oe  = 1'b1;
                bus_out = addr_q;
                cs_n    = 1'b0;
                wr_n    = 1'b0;
            end
            D_SET, D_HLD: begin
                if (!op_rd) begin
                    bus_oe  = 1'b1;
                    bus_out = wdata_q;
                end
            end
            D_STB: begin
                cs_n = 1'b0;
                if (op_rd) begin
                    rd_n = 1'b0;
                end else begin
                    wr_n    = 1'b0;
                    bus_oe  = 1'b1;
                    bus_out = wdata_q;
                end
            end
            default: ;
        endcase
    end

    assign busy  = (state != IDLE) && (state != DONE);
    assign done  = (state == DONE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Self-checking bench for rtc_bus_cycle: RTC bus model, result scoreboard, per-cycle bus invariants.
// Define RTC_WRITE_VERIFY_EN for both bench and RTL to exercise the write-verify build.
module tb_rtc_bus_cycle;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       busy, done, verify_err;
    logic [7:0] rdata;
    logic       ad, cs_n, wr_n, rd_n, bus_oe;
    logic [7:0] bus_out;
    logic [7:0] bus_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       verr;
        int         lat;
    } exp_t;
    exp_t sb[$];

    logic [7:0] rtc_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] lat_addr = 8'h00;
    logic [7:0] corrupt_mask = 8'h00;
    logic [7:0] exp_rdata = 8'h00;

    rtc_bus_cycle dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata),
        .verify_err(verify_err), .ad(ad), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    always #5 clk = ~clk;

    // RTC model: latches the address on the address strobe, stores (optionally corrupted) write data.
    always @(posedge clk) begin
        if (!cs_n && !ad && !wr_n) lat_addr <= bus_out;
        if (!cs_n && ad && !wr_n)  rtc_mem[lat_addr] <= bus_out ^ corrupt_mask;
    end
    assign bus_in = rd_n ? 8'h00 : rtc_mem[lat_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("wr_rd_excl", 32'(!wr_n && !rd_n), 0);
            check("oe_during_rd", 32'(bus_oe && !rd_n), 0);
            check("cs_only_strobe", 32'(!cs_n && wr_n && rd_n), 0);
        end
    end

    task automatic do_access(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                             input bit spam, input logic [7:0] corrupt);
        exp_t e;
        int a_stb = 0, ad0_bad = 0, wstb = 0, rstb = 0, quiet = 0, busy_cnt = 0;
        int exp_a, exp_w, exp_r, exp_q;
        bit got_done = 0;
        corrupt_mask = corrupt;
        if (wr) begin
`ifdef RTC_WRITE_VERIFY_EN
            exp_rdata = wdata ^ corrupt;
            e = '{rdata: exp_rdata, verr: (corrupt != 8'h00), lat: 69};
            exp_a = 20; exp_w = 10; exp_r = 10; exp_q = 16;
`else
            e = '{rdata: exp_rdata, verr: 1'b0, lat: 33};
            exp_a = 10; exp_w = 10; exp_r = 0; exp_q = 4;
`endif
            ref_mem[addr] = wdata ^ corrupt;
        end else begin
            exp_rdata = ref_mem[addr];
            e = '{rdata: exp_rdata, verr: 1'b0, lat: 33};
            exp_a = 10; exp_w = 0; exp_r = 10; exp_q = 8;
        end
        @(negedge clk);
        req = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0; req_addr = 8'hxx; req_wdata = 8'hxx;
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (!ad && !cs_n && !wr_n && bus_oe && bus_out == addr) a_stb++;
            if (!ad && (!bus_oe || bus_out != addr)) ad0_bad++;
            if (ad && !cs_n && !wr_n && bus_oe && bus_out == wdata) wstb++;
            if (ad && !cs_n && !rd_n && !bus_oe) rstb++;
            if (busy && !bus_oe && cs_n) quiet++;
            if (done) begin
                exp_t x;
                got_done = 1;
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    x = sb.pop_front();
                    check("rdata", rdata, x.rdata);
                    check("verify_err", verify_err, x.verr);
                    check("latency", n, x.lat);
                    check("busy_cycles", busy_cnt, x.lat - 1);
                end
                break;
            end
            req = spam && (n == 5 || n == 12);
            if (req) begin req_wr = 1'b0; req_addr = 8'h99; end
        end
        req = 1'b0;
        if (!got_done) check("done_timeout", 0, 1);
        check("addr_strobe", a_stb, exp_a);
        check("addr_bus_bad", ad0_bad, 0);
        check("wr_strobe", wstb, exp_w);
        check("rd_strobe", rstb, exp_r);
        check("quiet_cycles", quiet, exp_q);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("extra_done", done, 0);
            check("idle_busy", busy, 0);
            check("rdata_held", rdata, exp_rdata);
        end
    endtask

    task automatic reset_mid_write(input logic [7:0] addr, input logic [7:0] wdata);
        int dones = 0;
        @(negedge clk);
        req = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req = 1'b0;
        repeat (22) @(negedge clk);
        check("pre_rst_cs", cs_n, 0);
        check("pre_rst_wr", wr_n, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_cs", cs_n, 1);
        check("rst_wr", wr_n, 1);
        check("rst_oe", bus_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rtc_mem[i] = 8'(i);
            ref_mem[i] = 8'(i);
        end
        rtc_mem[8'h22] = 8'h37;
        ref_mem[8'h22] = 8'h37;
        reset = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ad", ad, 1);
        check("rst_strobes", {cs_n, wr_n, rd_n}, 3'b111);
        check("rst_bus_oe", bus_oe, 0);
        check("rst_bus_out", bus_out, 0);
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_verr", verify_err, 0);
        reset = 1'b0;

        do_access(1'b1, 8'h21, 8'h45, 1'b0, 8'h00);
        do_access(1'b0, 8'h22, 8'h00, 1'b0, 8'h00);
        do_access(1'b0, 8'h21, 8'h00, 1'b0, 8'h00);
        do_access(1'b1, 8'h40, 8'h66, 1'b1, 8'h00);
        reset_mid_write(8'h50, 8'hA5);
        exp_rdata = 8'h00;
        do_access(1'b0, 8'h22, 8'h00, 1'b0, 8'h00);
        do_access(1'b0, 8'h40, 8'h00, 1'b0, 8'h00);
`ifdef RTC_WRITE_VERIFY_EN
        do_access(1'b1, 8'h30, 8'h59, 1'b0, 8'h01);
        do_access(1'b1, 8'h31, 8'h12, 1'b0, 8'h00);
`endif
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
